sync7_serializer: RTL
=====================

Name: sync7_serializer

Overview:
- Downstream consumer of the 7-bit synchronous enabled register.
- Accepts the registered 7-bit word over a valid/ready handshake and shifts it out as a single-wire framed serial stream: start bit, 7 data bits LSB first, optional even-parity bit, stop bit.
- Bit period is a programmable number of clock cycles; all outputs are registered.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 1..255.
- PARITY_EN, 1, 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  word on i is offered this cycle
- i  input  7  parallel word from the upstream register
- in_ready  output  1  block can accept a word this cycle
- sout  output  1  serial line, idles high
- busy  output  1  a frame is in progress
- done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk. When rst=1 at an edge, the following values apply after that edge: state IDLE, sout=1, in_ready=1, busy=0, done=0, bit and cycle counters 0, shift register 0.
- rst has priority over every other input, including in_valid at the same edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: in_ready=1, busy=0, sout=1.
  - Accept condition: in_valid=1 and in_ready=1 at an edge (the accept edge E0).
  - On acceptance: i is captured into the shift register and the parity bit (XOR of i) is captured.
  - Next state is START. After E0: in_ready=0, busy=1, sout=0.
- Each serial bit holds sout stable for exactly CLKS_PER_BIT cycles. The cycle counter runs 0..CLKS_PER_BIT-1; the bit advances at terminal count.
- START: sout=0 for one bit period, then DATA.
- DATA: sout = shift register bit 0. After each bit period, shift right. After 7 bits, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: sout = captured parity bit (even parity: total ones across data and parity is even), for one bit period, then STOP.
- STOP: sout=1 for one bit period, then IDLE.
- Frame completion: the edge that enters IDLE also sets done=1 for exactly one cycle, in_ready=1 and busy=0.
- Latency: frame length F = (9+PARITY_EN)*CLKS_PER_BIT cycles. in_ready is low from E0+1 through E0+F-1 and high again after edge E0+F.
- Back-to-back frames: a word accepted in the same cycle that done=1 is legal. The next START begins immediately, with no extra idle cycle.
- Input is ignored while busy. Changes on i or in_valid while in_ready=0 have no effect; the captured word is not modified.
- Reset mid-frame aborts the frame: sout=1 after the reset edge, no done pulse, and the partial frame is discarded.
- CLKS_PER_BIT=1: each state lasts one cycle per bit, giving F=10 (parity on) or F=9 (parity off).
- No combinational path from inputs to outputs.

Test Plan:
- Reset check: assert rst for 2 cycles with in_valid=1 and i=7'h7F -> sout=1, in_ready=1, busy=0, done=0, and no frame starts.
- Basic frame (CLKS_PER_BIT=4, PARITY_EN=1): accept i=7'b1010011.
  - sout per 4-cycle bit: 0, 1,1,0,0,1,0,1, 0 (parity), 1 (stop).
  - done=1 exactly at E0+40; in_ready low for cycles E0+1..E0+39.
- Odd parity data: i=7'b0000111 -> parity bit 1. With PARITY_EN=0 the same word gives F=36 and no parity bit (stop immediately follows data bit 6).
- Back-to-back: hold in_valid=1 with i=7'h55, then i=7'h2A.
  - Second START begins at the edge after done.
  - Toggling i during the first frame does not alter its serial bits.
- Mid-frame reset: assert rst at E0+17 (inside DATA) -> sout=1 next cycle, no done pulse, in_ready=1. A new word accepted afterwards transmits correctly.
- CLKS_PER_BIT=1: accept 7'h01 -> sout sequence 0,1,0,0,0,0,0,0,1,1 on consecutive cycles, done at E0+10.

Source files
------------

// File: rtl/sync7_serializer.sv
// Serializes a 7-bit word into a framed single-wire stream:
// start bit, 7 data bits LSB first, optional even parity, stop bit.
module sync7_serializer #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          PARITY_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [6:0] i,
    output logic       in_ready,
    output logic       sout,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned BIT_W    = 3;
    localparam logic [CNT_W-1:0] TC  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(6);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [BIT_W-1:0] r_bit;
    logic [6:0]       r_shift;
    logic             r_par;
    logic             r_sout;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             w_tc;

    assign w_tc     = (r_cnt == TC);
    assign in_ready = r_ready;
    assign sout     = r_sout;
    assign busy     = r_busy;
    assign done     = r_done;

    // sout is loaded with the next bit's value on the same edge the state advances
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_sout  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (in_valid && r_ready) begin
                    r_shift <= i;
                    r_par   <= ^i;
                    r_cnt   <= '0;
                    r_state <= S_START;
                    r_sout  <= 1'b0;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                end
            end else if (!w_tc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_bit   <= '0;
                        r_sout  <= r_shift[0];
                    end
                    S_DATA: begin
                        r_shift <= r_shift >> 1;
                        if (r_bit == LAST_BIT) begin
                            if (PARITY_EN) begin
                                r_state <= S_PARITY;
                                r_sout  <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_sout  <= 1'b1;
                            end
                        end else begin
                            r_bit  <= r_bit + BIT_W'(1);
                            r_sout <= r_shift[1];
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP;
                        r_sout  <= 1'b1;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        r_sout  <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_sout  <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
